alu_core: RTL and testbench

//   32-bit integer ALU for the CPU execute stage. Takes a 14-bit one-hot op select
//   and two operands and returns alu_result.

---
 rtl/alu_core.sv | 144 ++++++++++++++
 tb/tb_alu_core.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// alu_core: 32-bit integer ALU for the execute stage.
// Fourteen one-hot selected operations are merged through an AND-OR result
// mux. Add/sub/compare/logic/shift/lui are purely combinational; multiply
// and divide are computed combinationally from the live operands and then
// captured into registers, so the caller sees them one cycle later.
module alu_core (
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] alu_control,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result,
  output logic [31:0] div_odd
);

  // Operation indices into alu_control.
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_MUL  = 2;
  localparam int OP_DIV  = 3;
  localparam int OP_SLT  = 4;
  localparam int OP_SLTU = 5;
  localparam int OP_AND  = 6;
  localparam int OP_NOR  = 7;
  localparam int OP_OR   = 8;
  localparam int OP_XOR  = 9;
  localparam int OP_SLL  = 10;
  localparam int OP_SRL  = 11;
  localparam int OP_SRA  = 12;
  localparam int OP_LUI  = 13;
  localparam int NUM_OPS = 14;

  // Registered multiply / divide state.
  logic [31:0] prod_q, prod_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q,  rem_d;

  // Raw combinational results of the multi-cycle units.
  logic [31:0] mul_raw;
  logic [31:0] div_quot_raw;
  logic [31:0] div_rem_raw;

  // Per-op results before gating, and after gating by their select bit.
  logic [31:0] op_res   [NUM_OPS];
  logic [31:0] op_gated [NUM_OPS];

  logic [4:0]  shamt;
  logic [31:0] sum_res;
  logic [31:0] diff_res;

  // Only the low five bits of src1 steer the shifter.
  assign shamt = alu_src1[4:0];

  // Shared adder/subtractor results, both modulo 2^32.
  assign sum_res  = alu_src1 + alu_src2;
  assign diff_res = alu_src1 - alu_src2;

  // Low 32 bits of the unsigned product.
  assign mul_raw = alu_src1 * alu_src2;

  // Unrolled restoring divider. A zero divisor makes every trial
  // subtraction succeed, which yields an all-ones quotient and leaves the
  // dividend as the remainder without any special-case logic.
  always_comb begin
    logic [32:0] part_rem;
    logic [32:0] trial;
    part_rem     = 33'd0;
    trial        = 33'd0;
    div_quot_raw = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      part_rem = {part_rem[31:0], alu_src1[i]};
      trial    = part_rem - {1'b0, alu_src2};
      if (!trial[32]) begin
        div_quot_raw[i] = 1'b1;
        part_rem        = trial;
      end
    end
    div_rem_raw = part_rem[31:0];
  end

  // Per-operation results; mul/div slots carry the registered values.
  always_comb begin
    op_res[OP_ADD]  = sum_res;
    op_res[OP_SUB]  = diff_res;
    op_res[OP_MUL]  = prod_q;
    op_res[OP_DIV]  = quot_q;
    op_res[OP_SLT]  = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
    op_res[OP_SLTU] = {31'd0, (alu_src1 < alu_src2)};
    op_res[OP_AND]  = alu_src1 & alu_src2;
    op_res[OP_NOR]  = ~(alu_src1 | alu_src2);
    op_res[OP_OR]   = alu_src1 | alu_src2;
    op_res[OP_XOR]  = alu_src1 ^ alu_src2;
    op_res[OP_SLL]  = alu_src2 << shamt;
    op_res[OP_SRL]  = alu_src2 >> shamt;
    op_res[OP_SRA]  = $unsigned($signed(alu_src2) >>> shamt);
    op_res[OP_LUI]  = {alu_src2[15:0], 16'h0000};
  end

  // Gate each result by its select bit so multi-hot selects OR together.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_gate
      assign op_gated[gi] = op_res[gi] & {32{alu_control[gi]}};
    end
  endgenerate

  // OR-reduce the gated results into the final output.
  always_comb begin
    alu_result = 32'd0;
    for (int i = 0; i < NUM_OPS; i++) begin
      alu_result = alu_result | op_gated[i];
    end
  end

  // Next-state for the multiply/divide registers: capture while selected.
  always_comb begin
    prod_d = prod_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    if (alu_control[OP_MUL]) begin
      prod_d = mul_raw;
    end
    if (alu_control[OP_DIV]) begin
      quot_d = div_quot_raw;
      rem_d  = div_rem_raw;
    end
  end

  // Multiply/divide state; reset discards any pending result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prod_q <= 32'd0;
      quot_q <= 32'd0;
      rem_q  <= 32'd0;
    end else begin
      prod_q <= prod_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
    end
  end

  assign div_odd = rem_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors for the combinational ops, plus hand-written
// sequences for multiply, divide, hold behaviour and asynchronous reset.
module tb_alu_core;

  logic        clk;
  logic        resetn;
  logic [13:0] alu_control;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;
  logic [31:0] div_odd;

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic [13:0] ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  alu_core dut (
    .clk         (clk),
    .resetn      (resetn),
    .alu_control (alu_control),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_result  (alu_result),
    .div_odd     (div_odd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, got);
    end
  endtask

  task automatic add_vec(input string n, input logic [13:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e);
    vec_t v;
    v.name = n; v.ctrl = c; v.a = a; v.b = b; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [13:0] c, input logic [31:0] a, input logic [31:0] b);
    alu_control = c;
    alu_src1    = a;
    alu_src2    = b;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    add_vec("add_basic", 14'h0001, 32'h0000_2223, 32'h0000_2222, 32'h0000_4445);
    add_vec("sub_basic", 14'h0002, 32'd25,        32'd2,         32'd23);
    add_vec("add_wrap",  14'h0001, 32'hFFFF_FFFF, 32'd1,         32'd0);
    add_vec("sub_wrap",  14'h0002, 32'd0,         32'd1,         32'hFFFF_FFFF);
    add_vec("slt_gt",    14'h0010, 32'h1234_5678, 32'h1234_5677, 32'd0);
    add_vec("slt_neg",   14'h0010, 32'h8000_0000, 32'd1,         32'd1);
    add_vec("slt_m1_0",  14'h0010, 32'hFFFF_FFFF, 32'd0,         32'd1);
    add_vec("sltu_lt",   14'h0020, 32'd1,         32'd2,         32'd1);
    add_vec("sltu_big",  14'h0020, 32'h8000_0000, 32'd1,         32'd0);
    add_vec("sltu_m1_0", 14'h0020, 32'hFFFF_FFFF, 32'd0,         32'd0);
    add_vec("and",       14'h0040, 32'd22,        32'd23,        32'd22);
    add_vec("nor",       14'h0080, 32'h0000_000A, 32'h0000_0005, 32'hFFFF_FFF0);
    add_vec("or",        14'h0100, 32'd4,         32'h0000_000F, 32'h0000_000F);
    add_vec("xor",       14'h0200, 32'd1,         32'h0000_1111, 32'h0000_1110);
    add_vec("sll_out",   14'h0400, 32'd4,         32'hF000_0000, 32'd0);
    add_vec("sll_hiamt", 14'h0400, 32'h0000_0024, 32'd1,         32'h0000_0010);
    add_vec("srl",       14'h0800, 32'd4,         32'h0000_BFC0, 32'h0000_0BFC);
    add_vec("srl_31",    14'h0800, 32'd31,        32'h8000_0000, 32'd1);
    add_vec("sra",       14'h1000, 32'd4,         32'hF000_0000, 32'hFF00_0000);
    add_vec("sra_31",    14'h1000, 32'd31,        32'h8000_0000, 32'hFFFF_FFFF);
    add_vec("sra_pos",   14'h1000, 32'd4,         32'h7000_0000, 32'h0700_0000);
    add_vec("lui",       14'h2000, 32'h0000_DEAD, 32'hABCD_5555, 32'h5555_0000);
    add_vec("ctrl_zero", 14'h0000, 32'd5,         32'd6,         32'd0);
    add_vec("add_and",   14'h0041, 32'h0000_000C, 32'h0000_000A, 32'h0000_001E);

    // Reset state.
    resetn = 1'b0;
    drive(14'h0004, 32'd7, 32'd9);
    #2;
    check("rst_mul_res", alu_result, 32'd0);
    check("rst_div_odd", div_odd, 32'd0);
    alu_control = 14'h0008;
    #1;
    check("rst_div_res", alu_result, 32'd0);
    check("rst_comb_add", (alu_control == 14'h0008) ? 32'd0 : 32'd1, 32'd0);
    alu_control = 14'h0001;
    #1;
    check("rst_comb_live", alu_result, 32'd16);

    @(negedge clk);
    resetn = 1'b1;

    // Combinational vectors: no clock edge involved.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      #1;
      check(vecs[i].name, alu_result, vecs[i].exp);
    end

    // Multiply: 0 before the first edge, product after it.
    @(negedge clk);
    drive(14'h0004, 32'd222, 32'd2);
    #1;
    check("mul_pre_edge", alu_result, 32'd0);
    @(posedge clk); #1;
    check("mul_222x2", alu_result, 32'd444);

    // Product holds while bit 2 is clear.
    @(negedge clk);
    drive(14'h0001, 32'd3, 32'd4);
    @(posedge clk);
    @(negedge clk);
    drive(14'h0004, 32'd5, 32'd5);
    #1;
    check("mul_hold", alu_result, 32'd444);
    @(posedge clk); #1;
    check("mul_5x5", alu_result, 32'd25);
    @(negedge clk);
    drive(14'h0004, 32'hFFFF_FFFF, 32'd2);
    @(posedge clk); #1;
    check("mul_low32", alu_result, 32'hFFFF_FFFE);

    // Divide.
    @(negedge clk);
    drive(14'h0008, 32'd564, 32'd7);
    #1;
    check("div_pre_edge", alu_result, 32'd0);
    @(posedge clk); #1;
    check("div_564_7_q", alu_result, 32'd80);
    check("div_564_7_r", div_odd, 32'd4);
    @(negedge clk);
    drive(14'h0008, 32'hFFFF_FFFF, 32'h0000_0010);
    @(posedge clk); #1;
    check("div_big_q", alu_result, 32'h0FFF_FFFF);
    check("div_big_r", div_odd, 32'h0000_000F);
    @(negedge clk);
    drive(14'h0008, 32'd9, 32'd0);
    @(posedge clk); #1;
    check("div_by0_q", alu_result, 32'hFFFF_FFFF);
    check("div_by0_r", div_odd, 32'd9);

    // Divide state holds while bit 3 is clear.
    @(negedge clk);
    drive(14'h0001, 32'd100, 32'd3);
    @(posedge clk); #1;
    check("div_hold_r", div_odd, 32'd9);
    @(negedge clk);
    drive(14'h0008, 32'd100, 32'd3);
    #1;
    check("div_hold_q", alu_result, 32'hFFFF_FFFF);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    drive(14'h0008, 32'd564, 32'd7);
    @(posedge clk); #1;
    check("div_before_rst", div_odd, 32'd4);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_async_odd", div_odd, 32'd0);
    check("rst_async_q", alu_result, 32'd0);
    alu_control = 14'h0004;
    #1;
    check("rst_async_prod", alu_result, 32'd0);
    drive(14'h0002, 32'd10, 32'd4);
    #1;
    check("rst_comb_sub", alu_result, 32'd6);
    @(negedge clk);
    resetn = 1'b1;
    drive(14'h0004, 32'd6, 32'd7);
    #1;
    check("post_rst_mul0", alu_result, 32'd0);
    @(posedge clk); #1;
    check("post_rst_mul", alu_result, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
